// File: rtl/stack_unit.sv
// stack_unit: parametrised operand stack with top/second/indexed reads, occupancy and sticky error flags
module stack_unit #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   parameter int CNT_W = $clog2(DEPTH+1),
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pop,
   input  logic             push,
   input  logic             load,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             clr_err,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [WIDTH-1:0] stk0,
   output logic [WIDTH-1:0] stk1,
   output logic [WIDTH-1:0] rd_data,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic             underflow
);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d, unf_q, unf_d;
   logic             do_push, do_pop, push_err, pop_err;
   always_comb begin
      do_push  = push && !pop;
      do_pop   = pop && !push;
      push_err = do_push && count_q == FULL_CNT;
      pop_err  = do_pop ? (count_q < (load ? TWO : ONE)) : (!do_push && load && count_q == '0);
      mem_d    = mem_q;
      count_d  = count_q;
      if (do_push && !push_err) begin
         for (int i = DEPTH-1; i > 0; i--) mem_d[i] = mem_q[i-1];
         mem_d[0] = wr_data;
         count_d  = count_q + ONE;
      end else if (do_pop && !pop_err) begin
         for (int i = 0; i < DEPTH-1; i++) mem_d[i] = mem_q[i+1];
         mem_d[DEPTH-1] = '0;
         if (load) mem_d[0] = wr_data;
         count_d = count_q - ONE;
      end else if (!do_push && load && !pop_err) begin
         mem_d[0] = wr_data;
      end
      // a new error in the same cycle as clr_err leaves the flag set
      ovf_d = (ovf_q && !clr_err) || push_err;
      unf_d = (unf_q && !clr_err) || pop_err;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q   <= '{default: '0};
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         mem_q   <= mem_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end
   assign stk0      = count_q > '0 ? mem_q[0] : '0;
   assign stk1      = count_q > ONE ? mem_q[1] : '0;
   assign rd_data   = CNT_W'(rd_idx) < count_q ? mem_q[rd_idx] : '0;
   assign count     = count_q;
   assign empty     = count_q == '0;
   assign full      = count_q == FULL_CNT;
   assign overflow  = ovf_q;
   assign underflow = unf_q;
endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: randomized and directed checks of stack_unit against a queue-based reference model
module tb_stack_unit;
   localparam int W = 16;
   localparam int D = 16;
   logic clk = 1'b0;
   logic rst, push, pop, load, clr_err;
   logic [W-1:0] wr_data;
   logic [3:0]   rd_idx;
   logic [W-1:0] stk0, stk1, rd_data;
   logic [4:0]   count;
   logic         empty, full, overflow, underflow;
   int checks = 0;
   int failures = 0;
   logic [W-1:0] q [$];
   bit m_ovf, m_unf;

   stack_unit #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .pop(pop), .push(push), .load(load), .wr_data(wr_data),
      .clr_err(clr_err), .rd_idx(rd_idx), .stk0(stk0), .stk1(stk1), .rd_data(rd_data),
      .count(count), .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] mexp(input int i);
      return (i < q.size()) ? q[i] : '0;
   endfunction

   // stack semantics straight from the operation rules; q[0] is the top
   task automatic op(input bit pu, input bit po, input bit ld, input logic [W-1:0] d, input bit clr);
      int n;
      @(negedge clk);
      push = pu; pop = po; load = ld; wr_data = d; clr_err = clr;
      @(posedge clk);
      #1;
      push = 0; pop = 0; load = 0; clr_err = 0;
      n = q.size();
      if (clr) begin m_ovf = 0; m_unf = 0; end
      if (pu && !po) begin
         if (n < D) q.push_front(d); else m_ovf = 1;
      end else if (po && !pu) begin
         if (n >= (ld ? 2 : 1)) begin
            void'(q.pop_front());
            if (ld) q[0] = d;
         end else m_unf = 1;
      end else if (ld) begin
         if (n >= 1) q[0] = d; else m_unf = 1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1;
      #2;
      rst = 0;
      q.delete();
      m_ovf = 0; m_unf = 0;
   endtask

   task automatic test_reset();
      do_reset();
      rd_idx = 0;
      #1;
      checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (stk0 !== 16'h0 || stk1 !== 16'h0 || rd_data !== 16'h0) begin failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", stk0, stk1, rd_data); end
      checks++; if ({empty, full, overflow, underflow} !== 4'b1000) begin failures++; $display("FAIL reset_flags got=%b exp=1000", {empty, full, overflow, underflow}); end
   endtask

   task automatic test_basic();
      do_reset();
      op(1, 0, 1, 16'h1111, 0);
      op(1, 0, 1, 16'h2222, 0);
      op(1, 0, 1, 16'h3333, 0);
      rd_idx = 2;
      #1;
      checks++; if (count !== 5'd3 || empty !== 1'b0) begin failures++; $display("FAIL basic_count got=%0d empty=%b exp=3 empty=0", count, empty); end
      checks++; if (stk0 !== 16'h3333 || stk1 !== 16'h2222) begin failures++; $display("FAIL basic_top got=%h/%h exp=3333/2222", stk0, stk1); end
      checks++; if (rd_data !== 16'h1111) begin failures++; $display("FAIL basic_rd2 got=%h exp=1111", rd_data); end
      op(0, 1, 1, 16'h5555, 0);
      checks++; if (count !== 5'd2 || stk0 !== 16'h5555 || stk1 !== 16'h1111) begin failures++; $display("FAIL basic_popload got=%0d %h/%h exp=2 5555/1111", count, stk0, stk1); end
      checks++; if (rd_data !== 16'h0) begin failures++; $display("FAIL basic_rd_beyond got=%h exp=0", rd_data); end
   endtask

   task automatic test_overflow();
      logic [W-1:0] top;
      do_reset();
      for (int i = 0; i < D; i++) op(1, 0, 1, W'($urandom), 0);
      top = q[0];
      rd_idx = 15;
      op(1, 0, 1, 16'hDEAD, 0);
      checks++; if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b1) begin failures++; $display("FAIL ovf_flags got cnt=%0d full=%b ovf=%b exp=16 1 1", count, full, overflow); end
      checks++; if (stk0 !== top || rd_data !== mexp(15)) begin failures++; $display("FAIL ovf_unchanged got=%h/%h exp=%h/%h", stk0, rd_data, top, mexp(15)); end
      op(0, 1, 0, 16'h0, 0);
      checks++; if (count !== 5'd15 || overflow !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL ovf_sticky got cnt=%0d ovf=%b full=%b exp=15 1 0", count, overflow, full); end
      checks++; if (rd_data !== 16'h0) begin failures++; $display("FAIL ovf_vacated got=%h exp=0", rd_data); end
      op(0, 0, 0, 16'h0, 1);
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
   endtask

   task automatic test_underflow();
      do_reset();
      op(0, 1, 0, 16'h0, 0);
      checks++; if (underflow !== 1'b1 || count !== 5'd0) begin failures++; $display("FAIL unf_pop got unf=%b cnt=%0d exp=1 0", underflow, count); end
      op(0, 0, 0, 16'h0, 1);
      op(1, 0, 1, 16'h4242, 0);
      checks++; if (underflow !== 1'b0 || stk0 !== 16'h4242) begin failures++; $display("FAIL unf_clear got unf=%b top=%h exp=0 4242", underflow, stk0); end
      op(0, 1, 1, 16'h9999, 0);
      checks++; if (underflow !== 1'b1 || stk0 !== 16'h4242 || count !== 5'd1) begin failures++; $display("FAIL unf_popload got unf=%b top=%h cnt=%0d exp=1 4242 1", underflow, stk0, count); end
      op(0, 0, 0, 16'h0, 1);
      op(0, 1, 0, 16'h0, 0);
      op(0, 0, 1, 16'h7777, 1);
      checks++; if (underflow !== 1'b1 || count !== 5'd0 || stk0 !== 16'h0) begin failures++; $display("FAIL unf_set_wins got unf=%b cnt=%0d top=%h exp=1 0 0", underflow, count, stk0); end
   endtask

   task automatic test_push_pop_load();
      logic [W-1:0] second;
      do_reset();
      for (int i = 0; i < 4; i++) op(1, 0, 1, W'($urandom), 0);
      second = q[1];
      op(1, 1, 1, 16'h00AA, 0);
      checks++; if (count !== 5'd4 || stk0 !== 16'h00AA || stk1 !== second) begin failures++; $display("FAIL ppl got cnt=%0d %h/%h exp=4 00aa/%h", count, stk0, stk1, second); end
      checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL ppl_flags got %b%b exp=00", overflow, underflow); end
      op(1, 1, 0, 16'hBEEF, 0);
      checks++; if (count !== 5'd4 || stk0 !== 16'h00AA || {overflow, underflow} !== 2'b00) begin failures++; $display("FAIL pp_nop got cnt=%0d top=%h fl=%b exp=4 00aa 00", count, stk0, {overflow, underflow}); end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < D; i++) op(1, 0, 1, W'($urandom), 0);
      op(1, 0, 1, 16'h1234, 0);
      for (int i = 0; i < 11; i++) op(0, 1, 0, 16'h0, 0);
      checks++; if (count !== 5'd5 || overflow !== 1'b1) begin failures++; $display("FAIL arst_setup got cnt=%0d ovf=%b exp=5 1", count, overflow); end
      @(negedge clk);
      #2;
      rst = 1;
      #1;
      checks++; if (count !== 5'd0 || stk0 !== 16'h0 || overflow !== 1'b0) begin failures++; $display("FAIL arst_immediate got cnt=%0d top=%h ovf=%b exp=0 0 0", count, stk0, overflow); end
      #1;
      rst = 0;
      q.delete();
      m_ovf = 0; m_unf = 0;
      op(1, 0, 1, 16'h7777, 0);
      rd_idx = 0;
      #1;
      checks++; if (count !== 5'd1 || rd_data !== 16'h7777 || stk1 !== 16'h0) begin failures++; $display("FAIL arst_first_push got cnt=%0d rd0=%h s1=%h exp=1 7777 0", count, rd_data, stk1); end
   endtask

   task automatic test_back_to_back();
      int r;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         r = $urandom_range(0, 99);
         rd_idx = 4'($urandom);
         // bias toward pushes early and pops later so both boundaries get hit
         if (r < ((c % 200) < 100 ? 50 : 15)) op(1, 0, $urandom_range(0, 1), W'($urandom), $urandom_range(0, 19) == 0);
         else if (r < 75) op(0, 1, $urandom_range(0, 1), W'($urandom), $urandom_range(0, 19) == 0);
         else if (r < 85) op(0, 0, 1, W'($urandom), 0);
         else if (r < 92) op(1, 1, $urandom_range(0, 1), W'($urandom), 0);
         else op(0, 0, 0, W'($urandom), $urandom_range(0, 1));
         checks++;
         if (count !== 5'(q.size()) || stk0 !== mexp(0) || stk1 !== mexp(1) || rd_data !== mexp(int'(rd_idx))) begin
            failures++;
            $display("FAIL rand_data cyc=%0d got cnt=%0d s0=%h s1=%h rd[%0d]=%h exp cnt=%0d s0=%h s1=%h rd=%h", c, count, stk0, stk1, rd_idx, rd_data, q.size(), mexp(0), mexp(1), mexp(int'(rd_idx)));
         end
         checks++;
         if ({empty, full, overflow, underflow} !== {q.size() == 0, q.size() == D, m_ovf, m_unf}) begin
            failures++;
            $display("FAIL rand_flags cyc=%0d got=%b exp=%b", c, {empty, full, overflow, underflow}, {q.size() == 0, q.size() == D, m_ovf, m_unf});
         end
      end
   endtask

   initial begin
      rst = 1; push = 0; pop = 0; load = 0; clr_err = 0; wr_data = '0; rd_idx = '0;
      test_reset();
      test_basic();
      test_overflow();
      test_underflow();
      test_push_pop_load();
      test_async_reset();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
